pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer with prioritized ret/call/jump/
//               conditional-branch redirection and a circular return-address
//               stack that overwrites its oldest entry when full.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          IMM_W     = 8,
  parameter int unsigned          RAS_DEPTH = 4,
  parameter logic [PC_W-1:0]      RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [1:0]        branch_cond,
  input  logic              zero,
  input  logic              negative,
  input  logic [IMM_W-1:0]  immediate,
  input  logic              jump_en,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic [PC_W-1:0]   jump_target,
  output logic [PC_W-1:0]   pc,
  output logic              redirect,
  output logic              ras_full,
  output logic              ras_empty,
  output logic              ras_err
);

  localparam int unsigned    PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned    CNT_W   = PTR_W + 1;
  localparam int unsigned    EXT_W   = PC_W - IMM_W;
  localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] C_CNT1  = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR1  = PTR_W'(1);
  localparam logic [PC_W-1:0]  C_PC1   = PC_W'(1);

  // Branch condition encodings
  localparam logic [1:0] C_COND_Z   = 2'b00;
  localparam logic [1:0] C_COND_NZ  = 2'b01;
  localparam logic [1:0] C_COND_AL  = 2'b10;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;     // next write slot; top entry is ptr_q-1
  logic             redirect_q, redirect_d;
  logic             err_q, err_d;
  logic             push;
  logic [PC_W-1:0]  stack_q [RAS_DEPTH];

  logic [PC_W-1:0]  pc_seq;
  logic [PC_W-1:0]  imm_ext;
  logic             take;
  logic             full;

  assign pc_seq  = pc_q + C_PC1;
  assign imm_ext = {{EXT_W{immediate[IMM_W-1]}}, immediate};
  assign full    = (count_q == C_FULL);

  // Evaluate whether the conditional branch is taken
  always_comb begin
    take = 1'b0;
    case (branch_cond)
      C_COND_Z:  take = zero;
      C_COND_NZ: take = ~zero;
      C_COND_AL: take = 1'b1;
      default:   take = negative;
    endcase
  end

  // Next-state selection in priority order: stall, ret, call, jump, branch, sequential
  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    err_d      = err_q;
    redirect_d = 1'b0;
    push       = 1'b0;
    if (stall) begin
      pc_d = pc_q;
    end else if (ret_en) begin
      if (count_q != '0) begin
        pc_d       = stack_q[ptr_q - C_PTR1];
        ptr_d      = ptr_q - C_PTR1;
        count_d    = count_q - C_CNT1;
        redirect_d = 1'b1;
      end else begin
        // Underflow falls through to sequential with no redirect
        pc_d  = pc_seq;
        err_d = 1'b1;
      end
    end else if (call_en) begin
      // A full stack wraps: the slot at ptr_q holds the oldest entry
      push       = 1'b1;
      ptr_d      = ptr_q + C_PTR1;
      pc_d       = jump_target;
      redirect_d = 1'b1;
      if (full) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + C_CNT1;
      end
    end else if (jump_en) begin
      pc_d       = jump_target;
      redirect_d = 1'b1;
    end else if (branch_en && take) begin
      pc_d       = pc_seq + imm_ext;
      redirect_d = 1'b1;
    end else begin
      pc_d = pc_seq;
    end
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      ptr_q      <= '0;
      redirect_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      redirect_q <= redirect_d;
      err_q      <= err_d;
    end
  end

  // Return-address storage; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[ptr_q] <= pc_seq;
    end
  end

  assign pc        = pc_q;
  assign redirect  = redirect_q;
  assign ras_full  = full;
  assign ras_empty = (count_q == '0);
  assign ras_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, branch_en, zero, negative, jump_en, call_en, ret_en;
  logic [1:0]  branch_cond;
  logic [7:0]  immediate;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic        redirect, ras_full, ras_empty, ras_err;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer #(
    .PC_W(32), .IMM_W(8), .RAS_DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_en(branch_en),
    .branch_cond(branch_cond), .zero(zero), .negative(negative),
    .immediate(immediate), .jump_en(jump_en), .call_en(call_en),
    .ret_en(ret_en), .jump_target(jump_target), .pc(pc),
    .redirect(redirect), .ras_full(ras_full), .ras_empty(ras_empty),
    .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_en = 0; jump_en = 0; call_en = 0; ret_en = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; idle(); branch_cond = 0; zero = 0; negative = 0;
    immediate = 0; jump_target = 0;
    #2;
    check("rst_pc", pc, 32'h0);
    check("rst_redirect", {31'b0, redirect}, 0);
    check("rst_empty", {31'b0, ras_empty}, 1);
    check("rst_full", {31'b0, ras_full}, 0);
    check("rst_err", {31'b0, ras_err}, 0);
    @(negedge clk); reset_n = 1;

    // Three idle cycles then two stalls
    step(); check("seq1", pc, 1);
    step(); check("seq2", pc, 2);
    step(); check("seq3", pc, 3); check("seq3_redir", {31'b0, redirect}, 0);
    stall = 1;
    step(); check("stall1", pc, 3);
    step(); check("stall2", pc, 3); check("stall_redir", {31'b0, redirect}, 0);
    stall = 0;

    // Branch if zero, backward offset -4: 10 + 1 - 4 = 7
    jump_en = 1; jump_target = 10;
    step(); check("jump10", pc, 10); check("jump_redir", {31'b0, redirect}, 1);
    idle(); branch_en = 1; branch_cond = 2'b00; zero = 1; immediate = 8'hFC;
    step(); check("bz_taken", pc, 7); check("bz_taken_redir", {31'b0, redirect}, 1);
    idle(); jump_en = 1; jump_target = 10;
    step();
    idle(); branch_en = 1; zero = 0;
    step(); check("bz_not", pc, 11); check("bz_not_redir", {31'b0, redirect}, 0);

    // Branch if nonzero +2: 11 + 1 + 2 = 14
    branch_cond = 2'b01; immediate = 8'h02;
    step(); check("bnz", pc, 14);
    // Branch if negative -128: 14 + 1 - 128 wraps
    branch_cond = 2'b11; negative = 1; immediate = 8'h80;
    step(); check("bneg", pc, 32'hFFFF_FF8F);
    negative = 0;
    step(); check("bneg_not", pc, 32'hFFFF_FF90); check("bneg_not_redir", {31'b0, redirect}, 0);

    // Wrap-around cases
    idle(); jump_en = 1; jump_target = 32'hFFFF_FFFF;
    step();
    idle();
    step(); check("wrap_seq", pc, 0);
    jump_en = 1; jump_target = 32'hFFFF_FFFE;
    step();
    idle(); branch_en = 1; branch_cond = 2'b10; immediate = 8'h05;
    step(); check("wrap_branch", pc, 4);

    // Five back-to-back calls from pc=1: pushes 2,101,102,103 then 104 overwrites 2
    idle(); jump_en = 1; jump_target = 1;
    step(); check("pc1", pc, 1);
    idle(); call_en = 1;
    jump_target = 100; step(); check("call1", pc, 100); check("call1_empty", {31'b0, ras_empty}, 0);
    jump_target = 101; step();
    jump_target = 102; step(); check("call3_full", {31'b0, ras_full}, 0);
    jump_target = 103; step(); check("call4_full", {31'b0, ras_full}, 1); check("call4_err", {31'b0, ras_err}, 0);
    jump_target = 104; step(); check("call5_pc", pc, 104);
    check("call5_err", {31'b0, ras_err}, 1); check("call5_full", {31'b0, ras_full}, 1);
    idle(); ret_en = 1;
    step(); check("ret1", pc, 104); check("ret1_redir", {31'b0, redirect}, 1); check("ret1_full", {31'b0, ras_full}, 0);
    step(); check("ret2", pc, 103);
    step(); check("ret3", pc, 102);
    step(); check("ret4", pc, 101); check("ret4_empty", {31'b0, ras_empty}, 1);
    step(); check("ret5_under", pc, 102); check("ret5_redir", {31'b0, redirect}, 0);
    check("ret5_err", {31'b0, ras_err}, 1); check("ret5_empty", {31'b0, ras_empty}, 1);

    // count=1 then ret+call+jump together: pop only
    idle(); call_en = 1; jump_target = 200;
    step(); check("call200", pc, 200);
    ret_en = 1; jump_en = 1; jump_target = 300;
    step(); check("multi_pc", pc, 103); check("multi_empty", {31'b0, ras_empty}, 1);
    check("multi_redir", {31'b0, redirect}, 1);
    // Stall overrides a call
    idle(); stall = 1; call_en = 1; jump_target = 400;
    step(); check("stallcall_pc", pc, 103); check("stallcall_empty", {31'b0, ras_empty}, 1);
    check("stallcall_redir", {31'b0, redirect}, 0);
    stall = 0;
    step(); check("call400", pc, 400); check("call400_empty", {31'b0, ras_empty}, 0);

    // Async reset pulse mid-cycle while a call is presented
    idle(); call_en = 1; jump_target = 500;
    @(negedge clk); reset_n = 0; #1;
    check("async_pc", pc, 0); check("async_empty", {31'b0, ras_empty}, 1);
    check("async_err", {31'b0, ras_err}, 0); check("async_redir", {31'b0, redirect}, 0);
    #1; reset_n = 1;
    idle(); ret_en = 1;
    step(); check("post_rst_under", pc, 1); check("post_rst_err", {31'b0, ras_err}, 1);
    check("post_rst_redir", {31'b0, redirect}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
